// File: rtl/task_stream_loader.sv
// -----------------------------------------------------------------------------
// task_stream_loader
//   Receives a task image over a credit-based flit stream and writes it into
//   memory. A task is a 4-flit header (text_size, data_size, bss_size, entry)
//   followed by (text_size+data_size)/4 payload words. The loader writes the
//   payload from BASE_ADDR upward, then zero-fills bss_size/4 words. It reports
//   completion with a one-cycle done_o pulse once the last write is acked.
//
// Ports
//   clk_i       clock, all state changes on rising edge
//   rst_ni      asynchronous active-low reset
//   rx_i        upstream flit valid
//   data_i      upstream flit
//   credit_o    ready; a flit moves when rx_i && credit_o
//   mem_we_o    memory write request (held until mem_ack_i)
//   mem_addr_o  write byte address
//   mem_data_o  write data
//   mem_ack_i   memory accepts the write when mem_we_o && mem_ack_i
//   entry_o     entry point of the last loaded task
//   done_o      one-cycle pulse after a task is fully written
//   busy_o      high in every state except S_TEXT
// -----------------------------------------------------------------------------
module task_stream_loader #(
  parameter int                    FLIT_SIZE  = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic [FLIT_SIZE-1:0]  data_i,
  output logic                  credit_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [FLIT_SIZE-1:0]  mem_data_o,
  input  logic                  mem_ack_i,
  output logic [FLIT_SIZE-1:0]  entry_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam logic [2:0] S_TEXT    = 3'd0;
  localparam logic [2:0] S_DATA    = 3'd1;
  localparam logic [2:0] S_BSS     = 3'd2;
  localparam logic [2:0] S_ENTRY   = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]            r_state;
  // r_live is 0 during reset and 1 from the first edge after release, so
  // credit_o cannot assert until the loader has actually seen a clock.
  logic                  r_live;
  logic [FLIT_SIZE-1:0]  r_text;
  logic [FLIT_SIZE-1:0]  r_data;
  logic [FLIT_SIZE-1:0]  r_bss;
  logic [FLIT_SIZE-2:0]  r_word_cnt;
  logic [FLIT_SIZE-3:0]  r_clr_cnt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [FLIT_SIZE-1:0]  r_wdata;
  logic [FLIT_SIZE-1:0]  r_entry;
  logic                  r_done;

  logic                  w_slot_free;
  logic                  w_credit;
  logic                  w_xfer;
  logic [FLIT_SIZE:0]    w_sum;
  logic [FLIT_SIZE-2:0]  w_word_cnt;
  logic [FLIT_SIZE-3:0]  w_clr_cnt;

  // The write register can take a new word when empty or draining this edge.
  assign w_slot_free = !r_we || mem_ack_i;
  assign w_xfer      = rx_i && w_credit;
  // One extra bit keeps text+data from overflowing before the word shift.
  assign w_sum       = {1'b0, r_text} + {1'b0, r_data};
  assign w_word_cnt  = (FLIT_SIZE-1)'(w_sum >> 2);
  assign w_clr_cnt   = (FLIT_SIZE-2)'(r_bss >> 2);

  always_comb begin
    w_credit = 1'b0;
    case (r_state)
      S_TEXT, S_DATA, S_BSS, S_ENTRY: w_credit = r_live;
      S_PAYLOAD:                      w_credit = r_live && w_slot_free;
      default:                        w_credit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_TEXT;
      r_live     <= 1'b0;
      r_text     <= '0;
      r_data     <= '0;
      r_bss      <= '0;
      r_word_cnt <= '0;
      r_clr_cnt  <= '0;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_entry    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_done <= 1'b0;
      // Default drain; a new write loaded below on the same edge overrides it.
      if (r_we && mem_ack_i) begin
        r_we <= 1'b0;
      end
      case (r_state)
        S_TEXT: if (w_xfer) begin
          r_text  <= data_i;
          r_state <= S_DATA;
        end
        S_DATA: if (w_xfer) begin
          r_data  <= data_i;
          r_state <= S_BSS;
        end
        S_BSS: if (w_xfer) begin
          r_bss   <= data_i;
          r_state <= S_ENTRY;
        end
        S_ENTRY: if (w_xfer) begin
          r_entry    <= data_i;
          r_word_cnt <= w_word_cnt;
          r_clr_cnt  <= w_clr_cnt;
          r_ptr      <= BASE_ADDR;
          if (w_word_cnt != '0)      r_state <= S_PAYLOAD;
          else if (w_clr_cnt != '0)  r_state <= S_CLEAR;
          else                       r_state <= S_DONE;
        end
        S_PAYLOAD: if (w_xfer) begin
          r_we       <= 1'b1;
          r_wdata    <= data_i;
          r_addr     <= r_ptr;
          r_ptr      <= r_ptr + ADDR_WIDTH'(4);
          r_word_cnt <= r_word_cnt - (FLIT_SIZE-1)'(1);
          if (r_word_cnt == (FLIT_SIZE-1)'(1)) begin
            r_state <= (r_clr_cnt != '0) ? S_CLEAR : S_DONE;
          end
        end
        S_CLEAR: if (w_slot_free) begin
          r_we      <= 1'b1;
          r_wdata   <= '0;
          r_addr    <= r_ptr;
          r_ptr     <= r_ptr + ADDR_WIDTH'(4);
          r_clr_cnt <= r_clr_cnt - (FLIT_SIZE-2)'(1);
          if (r_clr_cnt == (FLIT_SIZE-2)'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: if (!r_we) begin
          // done_o is registered: it is high in the cycle after leaving S_DONE.
          r_done  <= 1'b1;
          r_state <= S_TEXT;
        end
        default: r_state <= S_TEXT;
      endcase
    end
  end

  assign credit_o   = w_credit;
  assign mem_we_o   = r_we;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_wdata;
  assign entry_o    = r_entry;
  assign done_o     = r_done;
  assign busy_o     = (r_state != S_TEXT);

endmodule
